// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt/addi/lw/sw/beq/j)
// sharing one req/ready memory port for instruction fetch and data access.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   mem_req/mem_we      request (held until accepted), 1 = write
//   mem_addr/mem_wdata  word-aligned byte address and store data
//   mem_rdata/mem_ready read data and accept/complete strobe
//   pc/ula_result       architectural PC and ALUOut register
//   data_mem            memory data register (MDR)
//   retire/halt         instruction-complete pulse, sticky stop flag
module mips_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          NREGS           = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] ula_result,
    output logic [31:0] data_mem,
    output logic        retire,
    output logic        halt
);

    localparam int AW = $clog2(NREGS);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [AW-1:0] rs_idx;
    logic [AW-1:0] rt_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   imm_sext;
    logic [31:0]   eff_addr;
    logic [31:0]   r_res;
    logic          r_ok;

    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic          req_c;
    logic          retire_c;
    logic          illegal;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: AW];
    assign rt_idx   = ir_q[16 +: AW];
    assign rd_idx   = ir_q[11 +: AW];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign eff_addr = a_q + imm_sext;

    always_comb begin
        r_ok  = 1'b1;
        r_res = '0;
        case (funct)
            F_ADD:   r_res = a_q + b_q;
            F_SUB:   r_res = a_q - b_q;
            F_AND:   r_res = a_q & b_q;
            F_OR:    r_res = a_q | b_q;
            F_SLT:   r_res = {31'd0, $signed(a_q) < $signed(b_q)};
            default: r_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        tgt_d     = tgt_q;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        req_c     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = b_q;
        retire_c  = 1'b0;
        illegal   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs_idx];
                b_d     = regs_q[rt_idx];
                // pc_q already points past this instruction
                tgt_d   = pc_q + {imm_sext[29:0], 2'b00};
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (r_ok) begin
                            alu_d   = r_res;
                            state_d = S_WB;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    OP_ADDI: begin
                        alu_d   = eff_addr;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = eff_addr;
                        // misaligned access stops the core before the bus
                        state_d = (eff_addr[1:0] != 2'b00) ? S_HALT : S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = tgt_q;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_J: begin
                        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: illegal = 1'b1;
                endcase
                if (illegal) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_MEM: begin
                req_c    = 1'b1;
                mem_we   = (opcode == OP_SW);
                mem_addr = alu_q;
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                case (opcode)
                    OP_RTYPE: begin
                        rf_we    = 1'b1;
                        rf_waddr = rd_idx;
                        rf_wdata = alu_q;
                    end
                    OP_ADDI: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt_idx;
                        rf_wdata = alu_q;
                    end
                    OP_LW: begin
                        rf_we    = 1'b1;
                        rf_waddr = rt_idx;
                        rf_wdata = mdr_q;
                    end
                    default: rf_we = 1'b0;
                endcase
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (rf_we && rf_waddr != '0) regs_d[rf_waddr] = rf_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            tgt_q   <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            tgt_q   <= tgt_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // state resets to FETCH, so the request is masked while reset is low
    assign mem_req    = reset & req_c;
    assign retire     = reset & retire_c;
    assign halt       = (state_q == S_HALT);
    assign pc         = pc_q;
    assign ula_result = alu_q;
    assign data_mem   = mdr_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: word memory model with
// programmable wait states, store scoreboard and retire timing checks.
module tb_mips_multicycle;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic        is_imm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, mem_ready, retire, halt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] pc, ula_result, data_mem;

    logic        reset_b = 1'b0;
    logic        mem_req2, mem_we2, mem_ready2, retire2, halt2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;
    logic [31:0] pc2, ula_result2, data_mem2;

    logic [31:0] mem [256];
    st_t         exp_q[$];
    int          ret_cyc[$];
    logic [31:0] ret_pc[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int cyc2 = 0;
    int first2 = 0;
    int wait_n = 0;
    int wcnt = 0;
    int xfers = 0;
    logic        pend_q = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic        held_we;
    logic [31:0] st2_addr = '0;
    logic [31:0] st2_data = '0;

    always #5 clock = ~clock;

    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_ready2 = 1'b1;

    mips_multicycle #(
        .RESET_PC(32'h0), .NREGS(32), .HALT_ON_ILLEGAL(1'b1)
    ) u_dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .ula_result(ula_result), .data_mem(data_mem),
        .retire(retire), .halt(halt)
    );

    mips_multicycle #(
        .RESET_PC(32'h0), .NREGS(32), .HALT_ON_ILLEGAL(1'b0)
    ) u_dut_nop (
        .clock(clock), .reset(reset_b),
        .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
        .pc(pc2), .ula_result(ula_result2), .data_mem(data_mem2),
        .retire(retire2), .halt(halt2)
    );

    function automatic logic [31:0] r_type(input logic [5:0] f,
                                           input int rd, input int rs,
                                           input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op,
                                           input int rs, input int rt,
                                           input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    // fixed program for the HALT_ON_ILLEGAL=0 instance
    always_comb begin
        case (mem_addr2)
            32'h0:   mem_rdata2 = 32'hFC00_0000;
            32'h4:   mem_rdata2 = i_type(6'h08, 0, 1, 16'd9);
            32'h8:   mem_rdata2 = i_type(6'h2B, 0, 1, 16'h0080);
            32'hC:   mem_rdata2 = j_type(26'd3);
            default: mem_rdata2 = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // called at a falling edge; advances one clock and returns at the next
    task automatic tick();
        logic done, req, rt, rt2;
        if (pend_q && mem_req) begin
            check("addr_stable", mem_addr, held_addr);
            check("wdata_stable", mem_wdata, held_wdata);
            check("we_stable", {31'd0, mem_we}, {31'd0, held_we});
        end
        req        = mem_req;
        done       = mem_req && mem_ready;
        pend_q     = mem_req && !mem_ready;
        held_addr  = mem_addr;
        held_wdata = mem_wdata;
        held_we    = mem_we;
        rt         = retire;
        rt2        = retire2;
        if (reset_b && mem_req2 && mem_we2) begin
            st2_addr = mem_addr2;
            st2_data = mem_wdata2;
        end
        @(posedge clock);
        cyc++;
        if (reset_b) cyc2++;
        if (rt2 && first2 == 0) first2 = cyc2;
        if (done) begin
            xfers++;
            wcnt = 0;
            if (held_we) begin
                mem[held_addr[9:2]] = held_wdata;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_store: got %h@%h, expected none",
                             held_wdata, held_addr);
                end else begin
                    st_t e;
                    e = exp_q.pop_front();
                    check("store_addr", held_addr, e.addr);
                    check("store_data", held_wdata, e.data);
                end
            end
        end else if (req) begin
            wcnt++;
        end else begin
            wcnt = 0;
        end
        #1;
        mem_ready = (wcnt >= wait_n);
        if (rt) begin
            ret_cyc.push_back(cyc);
            ret_pc.push_back(pc);
        end
        @(negedge clock);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[9:2]] = w;
    endtask

    task automatic push_st(input logic [31:0] a, input logic [31:0] d);
        st_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int waits);
        reset  = 1'b0;
        wait_n = waits;
        wcnt   = 0;
        mem_ready = (wait_n == 0);
        pend_q = 1'b0;
        exp_q.delete();
        ret_cyc.delete();
        ret_pc.delete();
        repeat (3) tick();
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        check("rst_ula", ula_result, 32'h0);
        check("rst_mdr", data_mem, 32'h0);
        xfers = 0;
        cyc   = 0;
        reset = 1'b1;
        #1;
        check("boot_req", {31'd0, mem_req}, 32'd1);
        check("boot_addr", mem_addr, 32'h0);
    endtask

    task automatic run_retires(input string name, input int n,
                               input int budget);
        int k = 0;
        while (ret_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (ret_cyc.size() < n) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d retires, expected %0d",
                     name, ret_cyc.size(), n);
        end
    endtask

    alu_vec_t vecs[11];

    initial begin
        mem_ready = 1'b1;
        vecs[0]  = '{"add",   6'h20, 1'b0, 16'h0005, 16'hFFFD, 32'h0000_0002};
        vecs[1]  = '{"sub",   6'h22, 1'b0, 16'h0005, 16'hFFFD, 32'h0000_0008};
        vecs[2]  = '{"and",   6'h24, 1'b0, 16'h00F0, 16'h0FF0, 32'h0000_00F0};
        vecs[3]  = '{"or",    6'h25, 1'b0, 16'h00F0, 16'h0F0F, 32'h0000_0FFF};
        vecs[4]  = '{"slt_f", 6'h2A, 1'b0, 16'h0005, 16'hFFFD, 32'h0000_0000};
        vecs[5]  = '{"slt_t", 6'h2A, 1'b0, 16'hFFFD, 16'h0005, 32'h0000_0001};
        vecs[6]  = '{"slt_x", 6'h2A, 1'b0, 16'h7FFF, 16'h8000, 32'h0000_0000};
        vecs[7]  = '{"sub_w", 6'h22, 1'b0, 16'h0000, 16'h0001, 32'hFFFF_FFFF};
        vecs[8]  = '{"add_p", 6'h20, 1'b0, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE};
        vecs[9]  = '{"addi0", 6'h00, 1'b1, 16'hFFFF, 16'h0001, 32'h0000_0000};
        vecs[10] = '{"addin", 6'h00, 1'b1, 16'h8000, 16'h8000, 32'hFFFF_0000};

        // reset/idle plus table-driven ALU operations
        for (int v = 0; v < 11; v++) begin
            clear_mem();
            put(32'h00, i_type(6'h08, 0, 1, vecs[v].a));
            put(32'h04, i_type(6'h08, 0, 2, vecs[v].b));
            if (vecs[v].is_imm)
                put(32'h08, i_type(6'h08, 1, 3, vecs[v].b));
            else
                put(32'h08, r_type(vecs[v].funct, 3, 1, 2));
            put(32'h0C, i_type(6'h2B, 0, 3, 16'h0080));
            put(32'h10, j_type(26'd4));
            do_reset(0);
            push_st(32'h80, vecs[v].exp);
            run_retires(vecs[v].name, 4, 40);
            check({vecs[v].name, "_sb"}, exp_q.size(), 0);
        end

        // ALU sequence with zero-wait memory
        clear_mem();
        put(32'h00, i_type(6'h08, 0, 1, 16'd5));
        put(32'h04, i_type(6'h08, 0, 2, 16'hFFFD));
        put(32'h08, r_type(6'h20, 3, 1, 2));
        put(32'h0C, r_type(6'h2A, 4, 2, 1));
        put(32'h10, r_type(6'h22, 5, 2, 1));
        put(32'h14, i_type(6'h2B, 0, 3, 16'h0080));
        put(32'h18, i_type(6'h2B, 0, 4, 16'h0084));
        put(32'h1C, i_type(6'h2B, 0, 5, 16'h0088));
        put(32'h20, j_type(26'd8));
        do_reset(0);
        push_st(32'h80, 32'h0000_0002);
        push_st(32'h84, 32'h0000_0001);
        push_st(32'h88, 32'hFFFF_FFF8);
        run_retires("alu_seq", 8, 60);
        for (int k = 0; k < 5; k++)
            check("alu_retire_cyc", ret_cyc[k], 4 * (k + 1));
        check("alu_pc5", ret_pc[4], 32'd20);
        check("alu_sb", exp_q.size(), 0);

        // load/store with two wait cycles per access
        clear_mem();
        put(32'h00, j_type(26'h10));
        put(32'h40, i_type(6'h08, 0, 1, 16'd5));
        put(32'h44, i_type(6'h2B, 0, 1, 16'h0008));
        put(32'h48, i_type(6'h23, 0, 6, 16'h0008));
        put(32'h4C, i_type(6'h2B, 0, 6, 16'h0084));
        put(32'h50, j_type(26'h14));
        do_reset(2);
        push_st(32'h08, 32'd5);
        push_st(32'h84, 32'd5);
        run_retires("ldst", 5, 80);
        check("sw_cycles", ret_cyc[2] - ret_cyc[1], 8);
        check("lw_cycles", ret_cyc[3] - ret_cyc[2], 9);
        check("lw_mdr", data_mem, 32'd5);
        check("ldst_sb", exp_q.size(), 0);

        // taken branch, jump, writes to $0
        clear_mem();
        put(32'h00, i_type(6'h08, 0, 1, 16'd5));
        put(32'h04, i_type(6'h08, 0, 0, 16'd7));
        put(32'h08, i_type(6'h2B, 0, 0, 16'h0080));
        put(32'h0C, i_type(6'h08, 0, 2, 16'd6));
        put(32'h10, i_type(6'h04, 1, 1, 16'd2));
        put(32'h14, i_type(6'h2B, 0, 1, 16'h0090));
        put(32'h18, i_type(6'h2B, 0, 1, 16'h0094));
        put(32'h1C, j_type(26'h40));
        put(32'h100, i_type(6'h2B, 0, 1, 16'h0084));
        put(32'h104, j_type(26'h41));
        do_reset(0);
        push_st(32'h80, 32'd0);
        push_st(32'h84, 32'd5);
        run_retires("br", 7, 60);
        check("beq_cycles", ret_cyc[4] - ret_cyc[3], 3);
        check("beq_taken_pc", ret_pc[4], 32'h1C);
        check("j_cycles", ret_cyc[5] - ret_cyc[4], 3);
        check("j_pc", ret_pc[5], 32'h100);
        check("br_sb", exp_q.size(), 0);

        // branch not taken
        clear_mem();
        put(32'h00, i_type(6'h08, 0, 1, 16'd5));
        put(32'h04, i_type(6'h08, 0, 2, 16'd6));
        put(32'h08, i_type(6'h08, 0, 3, 16'd1));
        put(32'h0C, i_type(6'h08, 0, 4, 16'd1));
        put(32'h10, i_type(6'h04, 1, 2, 16'd2));
        put(32'h14, j_type(26'd5));
        do_reset(0);
        run_retires("bnt", 5, 40);
        check("beq_nt_pc", ret_pc[4], 32'h14);
        check("beq_nt_cycles", ret_cyc[4] - ret_cyc[3], 3);

        // illegal opcode and illegal funct halt the core
        for (int v = 0; v < 2; v++) begin
            clear_mem();
            put(32'h00, (v == 0) ? 32'hFC00_0000 : r_type(6'h21, 3, 1, 2));
            do_reset(0);
            repeat (10) tick();
            check("ill_halt", {31'd0, halt}, 32'd1);
            check("ill_req", {31'd0, mem_req}, 32'd0);
            check("ill_retires", ret_cyc.size(), 0);
            check("ill_pc", pc, 32'h4);
        end

        // misaligned load halts without a bus access
        clear_mem();
        put(32'h00, i_type(6'h08, 0, 1, 16'd6));
        put(32'h04, i_type(6'h23, 1, 2, 16'd0));
        do_reset(0);
        repeat (12) tick();
        check("mis_halt", {31'd0, halt}, 32'd1);
        check("mis_retires", ret_cyc.size(), 1);
        check("mis_xfers", xfers, 2);
        check("mis_ula", ula_result, 32'd6);
        check("mis_req", {31'd0, mem_req}, 32'd0);

        // illegal opcode retires as a nop when halting is disabled
        reset_b = 1'b1;
        #1;
        repeat (20) tick();
        check("nop_halt", {31'd0, halt2}, 32'd0);
        check("nop_first_retire", first2, 3);
        check("nop_st_addr", st2_addr, 32'h80);
        check("nop_st_data", st2_data, 32'd9);
        check("nop_ula", ula_result2, 32'h80);
        check("nop_mdr", data_mem2, 32'h0);
        check("nop_pc", pc2, 32'hC);

        // asynchronous reset while a load waits in MEM
        clear_mem();
        put(32'h00, i_type(6'h23, 0, 2, 16'h0080));
        do_reset(0);
        tick();
        tick();
        wait_n = 1000;
        tick();
        tick();
        check("mid_req", {31'd0, mem_req}, 32'd1);
        check("mid_addr", mem_addr, 32'h80);
        check("mid_ula", ula_result, 32'h80);
        #2;
        reset = 1'b0;
        #1;
        check("async_req", {31'd0, mem_req}, 32'd0);
        check("async_pc", pc, 32'h0);
        check("async_ula", ula_result, 32'h0);
        check("async_we", {31'd0, mem_we}, 32'd0);
        @(negedge clock);
        do_reset(0);
        tick();
        check("refetch_pc", pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
